// File: rtl/hwag_pkg.sv
// Shared types and constants for the angle-generator scheduling blocks.
package hwag_pkg;

  localparam int ANGLE_WIDTH      = 24;
  localparam int ANGLE_TOP        = 7679;
  localparam int ANGLES_PER_TOOTH = 64;

  typedef logic [ANGLE_WIDTH-1:0] angle_t;

  // Commit FSM: shadow windows wait in PENDING until the next 720 deg wrap.
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_e;

  // Angle window: output active from set (inclusive) to reset (exclusive).
  typedef struct packed {
    angle_t set;
    angle_t reset;
  } ign_window_t;

endpackage

// File: rtl/hwag_ign_scheduler_if.sv
// Configuration port of the ignition scheduler.
// cfg_we and cfg_commit are single-cycle strobes with no back-pressure: the
// scheduler samples them on every clock edge. A rejected write is reported by
// a one-cycle cfg_err pulse, an applied commit by a one-cycle cfg_ack pulse;
// cfg_pending is high while a commit waits for the next 720 deg wrap.
interface hwag_ign_scheduler_if #(
  parameter int CH_NUM = 4
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic                   cfg_we;
  logic [CH_W-1:0]        cfg_ch;
  logic                   cfg_sel;
  hwag_pkg::angle_t       cfg_data;
  logic                   cfg_commit;
  logic                   cfg_pending;
  logic                   cfg_ack;
  logic                   cfg_err;
  hwag_pkg::commit_state_e dbg_state;

  modport master (
    output cfg_we, cfg_ch, cfg_sel, cfg_data, cfg_commit,
    input  cfg_pending, cfg_ack, cfg_err, dbg_state
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_sel, cfg_data, cfg_commit,
    output cfg_pending, cfg_ack, cfg_err, dbg_state
  );

endinterface

// File: rtl/hwag_window_check.sv
// Wrap-aware angle window comparator (combinational).
module hwag_window_check
  import hwag_pkg::*;
(
  input  ign_window_t window,
  input  angle_t      angle,
  output logic        active
);

  // set < reset: plain window; set > reset: window runs through 0; equal: off.
  always_comb begin
    active = 1'b0;
    if (window.set < window.reset) begin
      active = (angle >= window.set) && (angle < window.reset);
    end else if (window.set > window.reset) begin
      active = (angle >= window.set) || (angle < window.reset);
    end
  end

endmodule

// File: rtl/hwag_ign_scheduler.sv
// Ignition scheduler: per-channel angle windows, one shared comparator scanned
// round-robin, shadow windows committed atomically at the 720 deg wrap.
module hwag_ign_scheduler
  import hwag_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int ANGLE_WIDTH = hwag_pkg::ANGLE_WIDTH,
  parameter int ANGLE_TOP   = hwag_pkg::ANGLE_TOP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hwag_start,
  input  logic [ANGLE_WIDTH-1:0] angle,
  hwag_ign_scheduler_if.slave    cfg,
  output logic [CH_NUM-1:0]      ign_out
);

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  ign_window_t            shadow_q [CH_NUM];
  ign_window_t            shadow_d [CH_NUM];
  ign_window_t            active_q [CH_NUM];
  ign_window_t            active_d [CH_NUM];
  logic [CH_W-1:0]        scan_q, scan_d;
  logic [ANGLE_WIDTH-1:0] angle_prev_q, angle_prev_d;
  logic [CH_NUM-1:0]      ign_q, ign_d;
  commit_state_e          state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;

  logic wrap;
  logic apply;
  logic write_ok;
  logic scan_hit;

  // Backwards angle step while synchronised (normal wrap or resync reload).
  assign wrap  = hwag_start && (angle < angle_prev_q);
  assign apply = (state_q == PENDING) && (wrap || !hwag_start);

  assign write_ok = cfg.cfg_we && (state_q == IDLE)
                 && (cfg.cfg_data <= ANGLE_WIDTH'(ANGLE_TOP))
                 && ({1'b0, cfg.cfg_ch} < (CH_W+1)'(CH_NUM));

  // The comparator always sees the pre-edge active window of the scanned channel.
  hwag_window_check u_window_check (
    .window (active_q[scan_q]),
    .angle  (angle),
    .active (scan_hit)
  );

  // Commit FSM: IDLE -> PENDING on request, back to IDLE when the copy happens.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_commit) state_d = PENDING;
      end
      PENDING: begin
        if (apply) begin
          state_d = IDLE;
          ack_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow writes, atomic shadow-to-active copy, scan and output update.
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    ign_d        = ign_q;
    angle_prev_d = angle;
    err_d        = cfg.cfg_we && !write_ok;
    scan_d       = (scan_q == CH_W'(CH_NUM - 1)) ? '0 : scan_q + 1'b1;

    if (write_ok) begin
      if (cfg.cfg_sel) shadow_d[cfg.cfg_ch].reset = cfg.cfg_data;
      else             shadow_d[cfg.cfg_ch].set   = cfg.cfg_data;
    end

    // Writes are blocked while PENDING, so shadow_q is stable when copied.
    if (apply) active_d = shadow_q;

    if (!hwag_start) ign_d = '0;
    else             ign_d[scan_q] = scan_hit;
  end

  // State registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      scan_q       <= '0;
      angle_prev_q <= '0;
      ign_q        <= '0;
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      scan_q       <= scan_d;
      angle_prev_q <= angle_prev_d;
      ign_q        <= ign_d;
      state_q      <= state_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign cfg.cfg_pending = (state_q == PENDING);
  assign cfg.cfg_ack     = ack_q;
  assign cfg.cfg_err     = err_q;
  assign cfg.dbg_state   = state_q;
  assign ign_out         = ign_q;

endmodule

// File: tb/tb_hwag_ign_scheduler.sv
// Testbench for hwag_ign_scheduler: directed angle sweeps, expected output
// events queued by the stimulus and checked in order by a monitor.
module tb_hwag_ign_scheduler;
  import hwag_pkg::*;

  localparam int CH_NUM = 4;
  localparam int W      = 32;
  localparam int ANY_LO = 0;
  localparam int ANY_HI = 8191;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              hwag_start = 1'b0;
  logic [23:0]       angle = '0;
  logic [CH_NUM-1:0] ign_out;

  hwag_ign_scheduler_if #(.CH_NUM(CH_NUM)) cfg_if ();

  hwag_ign_scheduler #(.CH_NUM(CH_NUM)) dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .angle      (angle),
    .cfg        (cfg_if),
    .ign_out    (ign_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // entry = {ack, err, ign_out[3:0], min sampled angle[12:0], max sampled angle[12:0]}
  logic [W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [W-1:0] mk(input logic a, input logic e, input logic [3:0] ign,
                                      input int lo, input int hi);
    return {a, e, ign, 13'(lo), 13'(hi)};
  endfunction

  task automatic push(input logic a, input logic e, input logic [3:0] ign,
                      input int lo, input int hi);
    exp_q.push_back(mk(a, e, ign, lo, hi));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int a);
    angle = 24'(a);
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) step(a);
  endtask

  task automatic cfg_write(input int ch, input logic sel, input int data, input logic commit);
    cfg_if.cfg_we     = 1'b1;
    cfg_if.cfg_ch     = 2'(ch);
    cfg_if.cfg_sel    = sel;
    cfg_if.cfg_data   = 24'(data);
    cfg_if.cfg_commit = commit;
    @(posedge clk);
    #1;
    cfg_if.cfg_we     = 1'b0;
    cfg_if.cfg_commit = 1'b0;
  endtask

  task automatic commit_only();
    cfg_if.cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_if.cfg_commit = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ign"},     32'(ign_out), 32'd0);
    check({tag, "_pending"}, 32'(cfg_if.cfg_pending), 32'd0);
    check({tag, "_ack"},     32'(cfg_if.cfg_ack), 32'd0);
    check({tag, "_err"},     32'(cfg_if.cfg_err), 32'd0);
    check({tag, "_state"},   32'(cfg_if.dbg_state), 32'(IDLE));
  endtask

  // ---------------- monitor ----------------
  // Any ack/err pulse or ign_out change is an event; the angle the DUT sampled
  // on that edge must fall inside the queued bounds.
  initial begin
    logic [3:0]   prev_ign;
    logic [5:0]   obs;
    logic [W-1:0] e;
    int           a_s;
    int           lo;
    int           hi;
    prev_ign = '0;
    wait (rst === 1'b1);
    forever begin
      @(posedge clk);
      a_s = int'(angle);
      @(negedge clk);
      obs = {cfg_if.cfg_ack, cfg_if.cfg_err, ign_out};
      if (cfg_if.cfg_ack || cfg_if.cfg_err || (ign_out !== prev_ign)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: ack=%0b err=%0b ign=%b at angle %0d, none expected",
                   obs[5], obs[4], obs[3:0], a_s);
        end else begin
          e  = exp_q.pop_front();
          lo = int'(e[25:13]);
          hi = int'(e[12:0]);
          n_chk++;
          if (obs !== e[31:26]) begin
            n_fail++;
            $display("FAIL event: got ack=%0b err=%0b ign=%b, want ack=%0b err=%0b ign=%b (angle %0d)",
                     obs[5], obs[4], obs[3:0], e[31], e[30], e[29:26], a_s);
          end
          n_chk++;
          if (a_s < lo || a_s > hi) begin
            n_fail++;
            $display("FAIL event_angle: ign=%b seen at sampled angle %0d, want %0d..%0d",
                     obs[3:0], a_s, lo, hi);
          end
        end
      end
      prev_ign = ign_out;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cfg_if.cfg_we     = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_sel    = 1'b0;
    cfg_if.cfg_data   = '0;
    cfg_if.cfg_commit = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst        = 1'b1;
    hwag_start = 1'b1;

    // Pass A: all windows 0/0, nothing may fire
    sweep(0, 7679);
    check("passA_pending", 32'(cfg_if.cfg_pending), 32'd0);
    check("passA_ign", 32'(ign_out), 32'd0);

    // Pass B: program windows at angle 500, one illegal write, commit with last write
    sweep(0, 500);
    push(1'b0, 1'b1, 4'b0000, ANY_LO, ANY_HI);
    cfg_write(0, 1'b0, 1152, 1'b0);
    cfg_write(0, 1'b1, 1216, 1'b0);
    cfg_write(0, 1'b1, 7680, 1'b0);
    cfg_write(1, 1'b0, 2000, 1'b0);
    cfg_write(1, 1'b1, 2100, 1'b0);
    cfg_write(3, 1'b0, 7600, 1'b0);
    check("passB_pending_before", 32'(cfg_if.cfg_pending), 32'd0);
    cfg_write(3, 1'b1, 64, 1'b1);
    check("passB_pending_after", 32'(cfg_if.cfg_pending), 32'd1);
    check("passB_state", 32'(cfg_if.dbg_state), 32'(PENDING));
    sweep(501, 7679);
    check("passB_pending_end", 32'(cfg_if.cfg_pending), 32'd1);

    // Pass C: commit applied at wrap, windows now live
    push(1'b1, 1'b0, 4'b0000, 0, 0);
    push(1'b0, 1'b0, 4'b1000, 1, 4);
    push(1'b0, 1'b0, 4'b0000, 64, 67);
    push(1'b0, 1'b0, 4'b0001, 1152, 1155);
    push(1'b0, 1'b0, 4'b0000, 1216, 1219);
    push(1'b0, 1'b0, 4'b0010, 2000, 2003);
    push(1'b0, 1'b0, 4'b0000, 2100, 2103);
    push(1'b0, 1'b0, 4'b1000, 7600, 7603);
    sweep(0, 7679);
    check("passC_pending", 32'(cfg_if.cfg_pending), 32'd0);

    // Pass D: commit coincides with wrap; write while pending is rejected
    push(1'b0, 1'b0, 4'b0000, 64, 67);
    push(1'b0, 1'b1, 4'b0000, ANY_LO, ANY_HI);
    push(1'b0, 1'b0, 4'b0001, 1152, 1155);
    push(1'b0, 1'b0, 4'b0000, 1216, 1219);
    push(1'b0, 1'b0, 4'b0010, 2000, 2003);
    push(1'b0, 1'b0, 4'b0000, 2100, 2103);
    push(1'b0, 1'b0, 4'b1000, 7600, 7603);
    cfg_if.cfg_commit = 1'b1;
    step(0);
    cfg_if.cfg_commit = 1'b0;
    check("passD_pending_wrapcommit", 32'(cfg_if.cfg_pending), 32'd1);
    sweep(1, 100);
    cfg_write(0, 1'b0, 3000, 1'b0);
    check("passD_pending_after_bad_write", 32'(cfg_if.cfg_pending), 32'd1);
    sweep(101, 7679);

    // Pass E: commit applied at this wrap; then hwag_start drop with a commit pending
    push(1'b1, 1'b0, 4'b1000, 0, 0);
    push(1'b0, 1'b0, 4'b0000, 64, 67);
    push(1'b0, 1'b0, 4'b0001, 1152, 1155);
    push(1'b0, 1'b0, 4'b0000, 1216, 1219);
    push(1'b0, 1'b0, 4'b0010, 2000, 2003);
    push(1'b1, 1'b0, 4'b0000, 2050, 2050);
    sweep(0, 2050);
    cfg_write(2, 1'b0, 10, 1'b0);
    cfg_write(2, 1'b1, 20, 1'b1);
    check("passE_pending", 32'(cfg_if.cfg_pending), 32'd1);
    hwag_start = 1'b0;
    step(2050);
    check("drop_ign", 32'(ign_out), 32'd0);
    check("drop_ack", 32'(cfg_if.cfg_ack), 32'd1);
    check("drop_pending", 32'(cfg_if.cfg_pending), 32'd0);
    hwag_start = 1'b1;

    // Pass F: new ch2 window live; reset mid-window with a commit pending
    push(1'b0, 1'b0, 4'b1000, 0, 3);
    push(1'b0, 1'b0, 4'b1100, 10, 13);
    push(1'b0, 1'b0, 4'b1000, 20, 23);
    push(1'b0, 1'b0, 4'b0000, 64, 67);
    push(1'b0, 1'b0, 4'b0001, 1152, 1155);
    push(1'b0, 1'b0, 4'b0000, 1216, 1219);
    push(1'b0, 1'b0, 4'b0010, 2000, 2003);
    push(1'b0, 1'b0, 4'b0000, ANY_LO, ANY_HI);
    sweep(0, 2050);
    check("passF_ign_before_reset", 32'(ign_out), 32'd2);
    commit_only();
    #2;
    rst = 1'b0;
    #1;
    check_cleared("midreset");
    angle = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Pass G: everything cleared; commit of empty shadows yields only an ack
    push(1'b1, 1'b0, 4'b0000, 0, 0);
    sweep(0, 99);
    commit_only();
    check("passG_pending", 32'(cfg_if.cfg_pending), 32'd1);
    sweep(100, 7679);
    sweep(0, 200);
    check("passG_pending_end", 32'(cfg_if.cfg_pending), 32'd0);
    check("passG_ign", 32'(ign_out), 32'd0);

    repeat (10) @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d expected events never seen, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
